data_bus_responder: RTL and testbench

Responder end of the CPU data-memory interface. It receives the processor's data-side requests (`ram_addr`, `mem_rd`, `mem_wr`, `data_mem_in`) and decodes each address. Requests in the top 256-word page go to a small memory-mapped peripheral set: GPIO, status, a 4-deep transmit FIFO, a countdown timer and a cycle counter. All other requests pass through to the data RAM. It returns a single read-data word to the CPU and drains the transmit FIFO over a valid/ready byte stream.

---
 rtl/data_bus_responder.sv | 206 ++++++++++++++++++++
 tb/tb_data_bus_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// data_bus_responder
// Responder end of the CPU data-memory interface. Addresses whose page bits
// cpu_addr[11:8] equal MMIO_PAGE are served by a small peripheral set (GPIO,
// STATUS, TX FIFO, countdown timer, cycle counter). All other requests are
// forwarded to the data RAM.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low
//   cpu_addr   - 12-bit CPU word address
//   cpu_rd     - CPU read strobe
//   cpu_wr     - CPU write strobe
//   cpu_wdata  - 32-bit CPU write data
//   cpu_rdata  - 32-bit read data to CPU (combinational mux)
//   ram_rd     - read strobe to RAM (combinational)
//   ram_wr     - write strobe to RAM (combinational)
//   ram_rdata  - 32-bit RAM read data
//   gpio_out   - GPIO output register
//   tx_data    - head byte of the TX FIFO (0 when empty)
//   tx_valid   - TX FIFO non-empty
//   tx_ready   - downstream sink accepts tx_data
//   timer_irq  - sticky timer-expired level
module data_bus_responder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MMIO_PAGE  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [31:0] ram_rdata,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] IDX_GPIO   = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_TXDATA = 3'd2;
  localparam logic [2:0] IDX_TIMER  = 3'd3;
  localparam logic [2:0] IDX_CYCLES = 3'd4;

  logic          sel_s;
  logic          reg_hit_s;
  logic          wr_gpio_s;
  logic          wr_status_s;
  logic          wr_tx_s;
  logic          wr_timer_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic          overflow_set_s;
  logic [2:0]    tx_count_sat_s;
  logic [31:0]   status_s;
  logic [31:0]   mmio_rdata_s;

  logic [31:0]   gpio_r;
  logic [31:0]   timer_r;
  logic [31:0]   cycles_r;
  logic          expired_r;
  logic          overflow_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Only the first eight words of the MMIO page hold registers.
  assign sel_s       = (cpu_addr[11:8] == MMIO_PAGE);
  assign reg_hit_s   = sel_s && (cpu_addr[7:3] == 5'd0);
  assign wr_gpio_s   = cpu_wr && reg_hit_s && (cpu_addr[2:0] == IDX_GPIO);
  assign wr_status_s = cpu_wr && reg_hit_s && (cpu_addr[2:0] == IDX_STATUS);
  assign wr_tx_s     = cpu_wr && reg_hit_s && (cpu_addr[2:0] == IDX_TXDATA);
  assign wr_timer_s  = cpu_wr && reg_hit_s && (cpu_addr[2:0] == IDX_TIMER);

  assign ram_rd = cpu_rd && !sel_s;
  assign ram_wr = cpu_wr && !sel_s;

  assign tx_valid = (count_r != CW'(0));
  assign full_s   = (count_r == CW'(FIFO_DEPTH));
  assign pop_s    = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is leaving.
  assign push_ok_s      = wr_tx_s && (!full_s || pop_s);
  assign overflow_set_s = wr_tx_s && full_s && !pop_s;

  // Head byte is forced to 0 when empty so stale storage never shows.
  assign tx_data   = tx_valid ? mem_r[rd_ptr_r] : 8'd0;
  assign gpio_out  = gpio_r;
  assign timer_irq = expired_r;

  // Saturating occupancy field for STATUS[6:4].
  always_comb begin
    tx_count_sat_s = 3'd0;
    if (count_r > CW'(7)) begin
      tx_count_sat_s = 3'd7;
    end else begin
      tx_count_sat_s = 3'(count_r);
    end
  end

  assign status_s = {25'd0, tx_count_sat_s, overflow_r, expired_r,
                     !tx_valid, full_s};

  // MMIO read mux; unmapped words read 0.
  always_comb begin
    mmio_rdata_s = 32'd0;
    if (reg_hit_s) begin
      case (cpu_addr[2:0])
        IDX_GPIO:   mmio_rdata_s = gpio_r;
        IDX_STATUS: mmio_rdata_s = status_s;
        IDX_TIMER:  mmio_rdata_s = timer_r;
        IDX_CYCLES: mmio_rdata_s = cycles_r;
        default:    mmio_rdata_s = 32'd0;
      endcase
    end else begin
      mmio_rdata_s = 32'd0;
    end
  end

  assign cpu_rdata = sel_s ? mmio_rdata_s : ram_rdata;

  // GPIO register and free-running cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_r   <= 32'd0;
      cycles_r <= 32'd0;
    end else begin
      cycles_r <= cycles_r + 32'd1;
      if (wr_gpio_s) begin
        gpio_r <= cpu_wdata;
      end
    end
  end

  // Countdown timer and its sticky expired flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_r   <= 32'd0;
      expired_r <= 1'b0;
    end else begin
      if (wr_timer_s) begin
        timer_r <= cpu_wdata;
      end else if (timer_r != 32'd0) begin
        timer_r <= timer_r - 32'd1;
      end
      // A load always clears; expiry on the 1->0 step beats a W1C clear.
      if (wr_timer_s) begin
        expired_r <= 1'b0;
      end else if (timer_r == 32'd1) begin
        expired_r <= 1'b1;
      end else if (wr_status_s && cpu_wdata[2]) begin
        expired_r <= 1'b0;
      end
    end
  end

  // TX overflow flag: set by a dropped push, cleared by W1C on STATUS[3].
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (overflow_set_s) begin
      overflow_r <= 1'b1;
    end else if (wr_status_s && cpu_wdata[3]) begin
      overflow_r <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset since tx_data is gated by tx_valid.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_r[wr_ptr_r] <= cpu_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder. Stimulus tasks queue the
// expected read data and TX bytes; a negedge monitor pops and compares
// whenever the DUT presents a read or a TX handshake.
module tb_data_bus_responder;

  logic        clk;
  logic        reset;
  logic [11:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ram_rd;
  logic        ram_wr;
  logic [31:0] ram_rdata;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  localparam logic [31:0] RAM_VAL = 32'hCAFE0123;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd_q [$];
  logic [7:0]  exp_tx_q [$];
  logic [31:0] mon_rd_e;
  logic [7:0]  mon_tx_e;

  data_bus_responder #(.FIFO_DEPTH(4), .MMIO_PAGE(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr),
    .ram_rdata (ram_rdata),
    .gpio_out  (gpio_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every read and every accepted TX byte.
  always @(negedge clk) begin
    if (reset === 1'b1 && cpu_rd === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: unexpected read got %h expected none", cpu_rdata);
      end else begin
        mon_rd_e = exp_rd_q.pop_front();
        chk("rdata", cpu_rdata, mon_rd_e);
      end
    end
    if (reset === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_data: unexpected byte got %h expected none", tx_data);
      end else begin
        mon_tx_e = exp_tx_q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, mon_tx_e});
      end
    end
  end

  task automatic cyc_idle();
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic cyc_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = 1'b0;
  endtask

  task automatic cyc_rd(input logic [11:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    exp_rd_q.push_back(exp);
    cpu_addr = a; cpu_rd = 1'b1; cpu_wr = 1'b0;
  endtask

  // Release reset and read CYCLES in the first cycle after release.
  task automatic release_rd_cycles();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_rd_q.push_back(32'd0);
    cpu_addr = 12'hF04; cpu_rd = 1'b1; cpu_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cpu_addr = 12'd0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_wdata = 32'd0; ram_rdata = RAM_VAL; tx_ready = 1'b0;
    repeat (3) cyc_idle();

    // Reset state
    release_rd_cycles();
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    cyc_rd(12'hF04, 32'd1);
    cyc_rd(12'hF01, 32'h0000_0002);

    // GPIO and RAM pass-through
    cyc_wr(12'hF00, 32'hDEADBEEF);
    cyc_rd(12'hF00, 32'hDEADBEEF);
    #1 chk("gpio_out", gpio_out, 32'hDEADBEEF);
    cyc_wr(12'h010, 32'h1234_5678);
    #1 chk("ram_wr", {30'd0, ram_wr, ram_rd}, 32'd2);
    cyc_rd(12'h010, RAM_VAL);
    #1 chk("ram_rd", {30'd0, ram_wr, ram_rd}, 32'd1);
    cyc_rd(12'hF00, 32'hDEADBEEF);
    // Unmapped MMIO word: reads 0, write ignored
    cyc_wr(12'hF08, 32'hFFFF_FFFF);
    cyc_rd(12'hF08, 32'd0);
    cyc_rd(12'hF05, 32'd0);
    cyc_rd(12'hF00, 32'hDEADBEEF);

    // FIFO fill with overflow, then drain
    tx_ready = 1'b0;
    cyc_wr(12'hF02, 32'h11);
    cyc_wr(12'hF02, 32'h22);
    cyc_wr(12'hF02, 32'h33);
    cyc_wr(12'hF02, 32'h44);
    cyc_wr(12'hF02, 32'h55);
    cyc_rd(12'hF01, 32'h0000_0049);
    exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
    exp_tx_q.push_back(8'h33); exp_tx_q.push_back(8'h44);
    cyc_idle();
    tx_ready = 1'b1;
    repeat (4) cyc_idle();
    #1 chk("drain_tx_valid", {31'd0, tx_valid}, 32'd0);
    cyc_wr(12'hF01, 32'h8);
    cyc_rd(12'hF01, 32'h0000_0002);

    // Full FIFO with simultaneous push and pop
    tx_ready = 1'b0;
    cyc_wr(12'hF02, 32'hAA);
    cyc_wr(12'hF02, 32'hBB);
    cyc_wr(12'hF02, 32'hCC);
    cyc_wr(12'hF02, 32'hDD);
    exp_tx_q.push_back(8'hAA); exp_tx_q.push_back(8'hBB);
    exp_tx_q.push_back(8'hCC); exp_tx_q.push_back(8'hDD);
    exp_tx_q.push_back(8'h66);
    cyc_wr(12'hF02, 32'h66);
    tx_ready = 1'b1;
    cyc_rd(12'hF01, 32'h0000_0041);
    tx_ready = 1'b0;
    cyc_idle();
    tx_ready = 1'b1;
    repeat (4) cyc_idle();
    #1 chk("pp_tx_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Timer countdown and sticky irq
    cyc_wr(12'hF03, 32'd3);
    cyc_rd(12'hF03, 32'd3);
    cyc_rd(12'hF03, 32'd2);
    cyc_rd(12'hF03, 32'd1);
    #1 chk("irq_before", {31'd0, timer_irq}, 32'd0);
    cyc_rd(12'hF03, 32'd0);
    #1 chk("irq_expired", {31'd0, timer_irq}, 32'd1);
    cyc_rd(12'hF01, 32'h0000_0006);
    cyc_wr(12'hF01, 32'h4);
    cyc_rd(12'hF01, 32'h0000_0002);
    #1 chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
    cyc_wr(12'hF03, 32'd0);
    cyc_idle();
    cyc_idle();
    #1 chk("irq_load0", {31'd0, timer_irq}, 32'd0);
    cyc_rd(12'hF03, 32'd0);

    // Reset mid-drain: queued bytes, running timer and GPIO all cleared
    tx_ready = 1'b0;
    cyc_wr(12'hF02, 32'h01);
    cyc_wr(12'hF02, 32'h02);
    cyc_wr(12'hF02, 32'h03);
    cyc_wr(12'hF03, 32'd100);
    cyc_wr(12'hF00, 32'h5555_5555);
    cyc_idle();
    reset = 1'b0;
    tx_ready = 1'b1;
    release_rd_cycles();
    #1;
    chk("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst2_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst2_gpio", gpio_out, 32'd0);
    chk("rst2_irq", {31'd0, timer_irq}, 32'd0);
    cyc_rd(12'hF04, 32'd1);
    cyc_rd(12'hF03, 32'd0);
    cyc_rd(12'hF01, 32'h0000_0002);
    cyc_idle();
    #1;
    chk("rd_queue_left", exp_rd_q.size(), 32'd0);
    chk("tx_queue_left", exp_tx_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
